// File: rtl/pm_min_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pm_min_search_ctrl
// Purpose  : Scans the 64 path metrics held in an 8-row path-metric memory
//            (8 metrics per row) and reports the smallest metric, the state
//            that holds it, and whether that minimum has grown large enough
//            that the metrics should be normalised.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            start             - one-cycle search request (ignored while busy)
//            pm_rd_en/addr     - memory read strobe and row address
//            pm_rd_data        - row data, returned one cycle after the read
//            busy              - search in progress
//            done              - one-cycle pulse when results update
//            best_state        - index {row, slice} of the minimum metric
//            best_metric       - minimum metric value (unsigned)
//            norm_req          - best_metric >= THRESH
// Revision : 1.0  initial release
// ============================================================================
module pm_min_search_ctrl #(
    parameter int         M      = 6,
    parameter logic [M:0] THRESH = (M+1)'(96)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               pm_rd_en,
    output logic [2:0]         pm_rd_addr,
    input  logic [8*(M+1)-1:0] pm_rd_data,
    output logic               busy,
    output logic               done,
    output logic [5:0]         best_state,
    output logic [M:0]         best_metric,
    output logic               norm_req
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_accept;

    logic [2:0] r_row;       // row currently being read
    logic [2:0] r_row_d;     // row whose data is on pm_rd_data this cycle
    logic       r_rd_vld;    // pm_rd_data carries a requested row

    logic [M:0] r_run_min;
    logic [5:0] r_run_idx;

    logic [M:0] w_row_min;
    logic [2:0] w_row_slice;
    logic       w_take;
    logic [M:0] w_fin_min;
    logic [5:0] w_fin_idx;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        pm_rd_en    = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = READ;
                end
            end
            READ: begin
                pm_rd_en = 1'b1;
                busy     = 1'b1;
                if (r_row == 3'd7) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The row counter wraps 7 -> 0 on the last read, so it already reads
    // as 0 in DRAIN and IDLE and can drive the address directly.
    assign pm_rd_addr = r_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row    <= 3'd0;
            r_row_d  <= 3'd0;
            r_rd_vld <= 1'b0;
        end else begin
            r_row_d  <= r_row;
            r_rd_vld <= pm_rd_en;
            if (w_accept) begin
                r_row <= 3'd0;
            end else if (r_state == READ) begin
                r_row <= r_row + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Row minimum: strict less-than while scanning upward keeps the lowest
    // slice index on ties.
    // ------------------------------------------------------------------
    always_comb begin
        w_row_min   = pm_rd_data[M:0];
        w_row_slice = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (pm_rd_data[i*(M+1) +: (M+1)] < w_row_min) begin
                w_row_min   = pm_rd_data[i*(M+1) +: (M+1)];
                w_row_slice = 3'(i);
            end
        end
    end

    // Earlier rows win ties against later rows, hence strict less-than.
    assign w_take    = r_rd_vld && (w_row_min < r_run_min);
    assign w_fin_min = w_take ? w_row_min : r_run_min;
    assign w_fin_idx = w_take ? {r_row_d, w_row_slice} : r_run_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_min <= '1;
            r_run_idx <= 6'd0;
        end else if (w_accept) begin
            r_run_min <= '1;
            r_run_idx <= 6'd0;
        end else if (w_take) begin
            r_run_min <= w_row_min;
            r_run_idx <= {r_row_d, w_row_slice};
        end
    end

    // ------------------------------------------------------------------
    // Results: the last row is still being compared in DRAIN, so the
    // registered result takes the bypassed final minimum.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            best_state  <= 6'd0;
            best_metric <= '0;
            norm_req    <= 1'b0;
        end else begin
            done <= (r_state == DRAIN);
            if (r_state == DRAIN) begin
                best_state  <= w_fin_idx;
                best_metric <= w_fin_min;
                norm_req    <= (w_fin_min >= THRESH);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pm_min_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pm_min_search_ctrl
// Purpose  : Directed self-checking bench for pm_min_search_ctrl with a
//            behavioural path-metric memory (one-cycle read latency).
// Revision : 1.0  initial release
// ============================================================================
module tb_pm_min_search_ctrl;

    localparam int M = 6;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           pm_rd_en;
    logic [2:0]     pm_rd_addr;
    logic [8*(M+1)-1:0] pm_rd_data;
    logic           busy;
    logic           done;
    logic [5:0]     best_state;
    logic [M:0]     best_metric;
    logic           norm_req;

    logic [M:0]     mem [64];

    int n_checks = 0;
    int n_pass   = 0;

    pm_min_search_ctrl #(
        .M      (M),
        .THRESH (7'd96)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pm_rd_en    (pm_rd_en),
        .pm_rd_addr  (pm_rd_addr),
        .pm_rd_data  (pm_rd_data),
        .busy        (busy),
        .done        (done),
        .best_state  (best_state),
        .best_metric (best_metric),
        .norm_req    (norm_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: row data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (pm_rd_en) begin
            logic [8*(M+1)-1:0] row;
            for (int i = 0; i < 8; i++) begin
                row[i*(M+1) +: (M+1)] = mem[{pm_rd_addr, 3'(i)}];
            end
            pm_rd_data <= row;
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic fill(input int v);
        for (int s = 0; s < 64; s++) mem[s] = (M+1)'(v);
    endtask

    // Called #1 after a rising edge; start is raised in that cycle (cycle 0)
    // and the task returns in cycle 10, the expected done cycle.
    task automatic run_search(input string tag, input int es, input int em,
                              input int en, input bit repulse);
        int done_cyc = 0;
        int done_cnt = 0;
        int n_rd     = 0;
        bit seq_bad  = 1'b0;
        bit busy_bad = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 10; c++) begin
            if (pm_rd_en) begin
                if (int'(pm_rd_addr) != n_rd) seq_bad = 1'b1;
                n_rd++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (busy != (c <= 9)) busy_bad = 1'b1;
            start = repulse && (c == 3 || c == 9);
            if (c < 10) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        check({tag, ".done_cycle"}, (done_cnt == 1) ? done_cyc : 100 + done_cnt, 10);
        check({tag, ".addr_seq"}, seq_bad ? 99 : n_rd, 8);
        check({tag, ".busy"}, int'(busy_bad), 0);
        check({tag, ".best_state"}, int'(best_state), es);
        check({tag, ".best_metric"}, int'(best_metric), em);
        check({tag, ".norm_req"}, int'(norm_req), en);
    endtask

    // One cycle after done: pulse gone, no further reads, results held.
    task automatic idle_check(input string tag, input int es, input int em, input int en);
        @(posedge clk); #1;
        check({tag, ".done_low"}, int'(done), 0);
        check({tag, ".no_read"}, int'(pm_rd_en), 0);
        check({tag, ".hold"}, int'({best_state, best_metric, norm_req}),
              int'({6'(es), 7'(em), 1'(en)}));
    endtask

    initial begin
        int dcnt;
        start = 1'b0;
        rst_n = 1'b1;
        fill(0);
        #2 rst_n = 1'b0;
        #1;
        check("reset_outputs",
              int'({pm_rd_en, pm_rd_addr, busy, done, best_state, best_metric, norm_req}), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // metric[s] = s + 10
        for (int s = 0; s < 64; s++) mem[s] = 7'(s + 10);
        run_search("ramp", 0, 10, 0, 1'b0);
        idle_check("ramp", 0, 10, 0);

        // two minima of 3 at states 45 and 61: the earlier row wins
        fill(50); mem[45] = 7'd3; mem[61] = 7'd3;
        run_search("tie_rows", 45, 3, 0, 1'b0);

        fill(127);
        run_search("all_max", 0, 127, 1, 1'b0);

        fill(127); mem[20] = 7'd96;
        run_search("min96", 20, 96, 1, 1'b0);

        fill(127); mem[63] = 7'd95;
        run_search("min95", 63, 95, 0, 1'b0);

        // tie inside a row beats a later row; start re-pulsed while busy
        fill(100); mem[7] = 7'd99; mem[8] = 7'd99; mem[3] = 7'd101;
        run_search("repulse", 7, 99, 1, 1'b1);
        idle_check("repulse", 7, 99, 1);

        // back-to-back: second start in the done cycle of the first
        fill(110); mem[12] = 7'd98; mem[13] = 7'd98;
        run_search("b2b_a", 12, 98, 1, 1'b0);
        for (int s = 0; s < 64; s++) mem[s] = 7'(127 - s);
        run_search("b2b_b", 63, 64, 0, 1'b0);
        idle_check("b2b_b", 63, 64, 0);

        // reset in cycle 5 of a search
        fill(80); mem[33] = 7'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              int'({pm_rd_en, pm_rd_addr, busy, done, best_state, best_metric, norm_req}), 0);
        dcnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        check("midreset_no_done", dcnt, 0);
        run_search("after_reset", 33, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
